// File: rtl/vector_bitwise_seq_unit.sv
// Multi-cycle vector logic / min-max / reduction unit: walks a VLEN-bit operand
// pair DATAPATH bits per beat with per-element masking and valid/ready handshakes.
module vector_bitwise_seq_unit #(
  parameter int VLEN     = 128,
  parameter int ELEN     = 32,
  parameter int DATAPATH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VLEN-1:0]   dataA,
  input  logic [VLEN-1:0]   dataB,
  input  logic [VLEN/8-1:0] vmask,
  input  logic              vm,
  input  logic [4:0]        bitwise_op,
  input  logic [1:0]        sew,
  output logic [VLEN-1:0]   bitwise_result,
  output logic              bitwise_done,
  input  logic              out_ready,
  output logic              error
);

  localparam int BEATS = VLEN / DATAPATH;
  localparam int MAXEL = VLEN / 8;
  localparam int MAXK  = DATAPATH / 8;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (MAXEL > 1) ? $clog2(MAXEL) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // kind: 0 AND, 1 OR, 2 XOR, 3 NOT(x), 4 MINU, 5 MIN, 6 MAXU, 7 MAX
  function automatic logic [ELEN-1:0] alu(input logic [ELEN-1:0] x,
                                          input logic [ELEN-1:0] y,
                                          input logic [2:0]      kind,
                                          input logic [ELEN-1:0] sbit);
    logic lt_u;
    logic lt_s;
    lt_u = (x < y);
    lt_s = ((x ^ sbit) < (y ^ sbit));
    case (kind)
      3'd0:    alu = x & y;
      3'd1:    alu = x | y;
      3'd2:    alu = x ^ y;
      3'd3:    alu = ~x;
      3'd4:    alu = lt_u ? x : y;
      3'd5:    alu = lt_s ? x : y;
      3'd6:    alu = lt_u ? y : x;
      default: alu = lt_s ? y : x;
    endcase
  endfunction

  logic [VLEN-1:0]  a_q, b_q;
  logic [MAXEL-1:0] vmask_q;
  logic             vm_q;
  logic [4:0]       op_q;
  logic [1:0]       sew_q;

  state_t           state_q;
  logic [BW-1:0]    beat_q;
  logic [ELEN-1:0]  acc_q;
  logic [VLEN-1:0]  res_q;
  logic             done_q, err_q, ready_q;

  int               esz, esz_in, nel;
  logic [ELEN-1:0]  emask, seed_mask, sbit, ea, eb, r, acc_d;
  logic [DATAPATH-1:0] sa, sb, slice_d;
  logic [IW-1:0]    idx;
  logic             act, bad;
  logic [4:0]       rk;
  logic [2:0]       rkind;

  always_comb begin
    case (sew_q)
      2'b01:   esz = 16;
      2'b10:   esz = 32;
      default: esz = 8;
    endcase
    case (sew)
      2'b01:   esz_in = 16;
      2'b10:   esz_in = 32;
      default: esz_in = 8;
    endcase
    nel       = DATAPATH / esz;
    emask     = {ELEN{1'b1}} >> (ELEN - esz);
    seed_mask = {ELEN{1'b1}} >> (ELEN - esz_in);
    sbit      = ELEN'(1) << (esz - 1);
    sa        = a_q[int'(beat_q)*DATAPATH +: DATAPATH];
    sb        = b_q[int'(beat_q)*DATAPATH +: DATAPATH];
    // Reduction opcodes 8..14 map onto ALU kinds, skipping NOT
    rk        = op_q - 5'd8;
    rkind     = (rk < 5'd3) ? rk[2:0] : rk[2:0] + 3'd1;
    bad       = (sew_q == 2'b11) || (op_q > 5'd14);
    acc_d     = acc_q;
    slice_d   = '0;
    ea        = '0;
    eb        = '0;
    r         = '0;
    idx       = '0;
    act       = 1'b0;
    for (int k = 0; k < MAXK; k++) begin
      if (k < nel) begin
        ea  = ELEN'(sa >> (k * esz)) & emask;
        eb  = ELEN'(sb >> (k * esz)) & emask;
        idx = IW'(int'(beat_q) * nel + k);
        act = vm_q | vmask_q[idx];
        if (op_q[3]) begin
          if (act) acc_d = alu(acc_d, ea, rkind, sbit) & emask;
        end else begin
          r       = act ? (alu(ea, eb, op_q[2:0], sbit) & emask) : '0;
          slice_d = slice_d | (DATAPATH'(r) << (k * esz));
        end
      end
    end
  end

  // Operand capture; data only, so no reset
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_q     <= dataA;
      b_q     <= dataB;
      vmask_q <= vmask;
      vm_q    <= vm;
      op_q    <= bitwise_op;
      sew_q   <= sew;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= RUN;
            ready_q <= 1'b0;
            beat_q  <= '0;
            res_q   <= '0;
            acc_q   <= dataB[ELEN-1:0] & seed_mask;
          end
        end
        RUN: begin
          // Illegal commands spend one cycle here so done arrives one edge after accept
          if (bad) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            acc_q <= acc_d;
            if (!op_q[3]) res_q[int'(beat_q)*DATAPATH +: DATAPATH] <= slice_d;
            if (beat_q == BW'(BEATS - 1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              if (op_q[3]) res_q <= VLEN'(acc_d);
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = ready_q;
  assign bitwise_result = res_q;
  assign bitwise_done   = done_q;
  assign error          = err_q;

endmodule

// File: doc/vector_bitwise_seq_unit.md
Name: vector_bitwise_seq_unit

Overview:
- Multi-cycle, parametrised vector logic/min-max unit for the vector execution lane.
- Processes a VLEN-bit operand pair DATAPATH bits per beat, with SEW 8/16/32.
- Adds over the combinational bitwise unit: per-element masking, reductions, and a valid/ready handshake on both sides.
- Sits between the vector operand collector and the writeback arbiter.

Parameters:
- VLEN, 128, vector register width in bits; must be a multiple of DATAPATH.
- ELEN, 32, maximum element width.
- DATAPATH, 32, bits processed per beat; must be ≥ ELEN and a power of two.
- Derived: BEATS = VLEN/DATAPATH; MAXEL = VLEN/8.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand/command valid
- in_ready  out  1  unit idle, can accept a command
- dataA  in  VLEN  vector source A (vs2)
- dataB  in  VLEN  vector source B (vs1); element 0 is the scalar seed for reductions
- vmask  in  MAXEL  per-element mask bits; bit i belongs to element i
- vm  in  1  1 = unmasked, 0 = use vmask
- bitwise_op  in  5  0 AND, 1 OR, 2 XOR, 3 NOT(A), 4 MINU, 5 MIN, 6 MAXU, 7 MAX, 8 REDAND, 9 REDOR, 10 REDXOR, 11 REDMINU, 12 REDMIN, 13 REDMAXU, 14 REDMAX
- sew  in  2  00 = 8, 01 = 16, 10 = 32, 11 = illegal
- bitwise_result  out  VLEN  result vector, registered
- bitwise_done  out  1  result valid (level, held until accepted)
- out_ready  in  1  consumer accepts result
- error  out  1  illegal op/sew flag, valid while bitwise_done=1

Behaviour:
- Reset, asynchronous, any state: FSM=IDLE, beat counter=0, accumulator=0, bitwise_result=0, bitwise_done=0, error=0. in_ready=1 once the FSM is in IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch dataA, dataB, vmask, vm, op and sew; clear bitwise_result.
  - If sew=11 or op>14: go to DONE with error=1 and result=0.
  - Otherwise go to RUN with beat=0. For reductions, accumulator ← dataB element 0, zero-extended to ELEN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle processes slice [beat*DATAPATH +: DATAPATH], holding DATAPATH/SEW elements. Global element index = beat*(DATAPATH/SEW)+k.
  - Element-wise ops (0–7): active element result written into the same slice of bitwise_result. Inactive element (vm=0 && vmask[idx]=0) written as 0.
  - NOT ignores dataB. MIN/MAX compare signed at SEW width; MINU/MAXU compare unsigned.
  - Reductions (8–14): active elements of A fold into the accumulator in ascending index order (combinational chain within a beat). Inactive elements are skipped.
  - At beat=BEATS-1, go to DONE.
  - Reduction result: element 0 (SEW bits) of bitwise_result = accumulator[SEW-1:0]; all other bits 0. If all elements are inactive, the result is dataB element 0.
- DONE:
  - bitwise_done=1; bitwise_result and error held stable.
  - On out_ready go to IDLE. bitwise_done and error drop on that edge; bitwise_result is retained until the next accept.
- Latency: bitwise_done rises exactly BEATS clk edges after the accept edge (legal), or 1 edge after it (illegal). Throughput is one command per BEATS+2 cycles minimum.
- out_ready high in the same cycle bitwise_done rises: accepted on that edge.
- vmask bits ≥ VLEN/SEW are ignored.
- Reset during RUN or DONE aborts the command; no done pulse is produced.

Test Plan:
- VLEN=128, DATAPATH=32, SEW=8 AND, A byte i = i+1, B byte i = F0-i, vm=1 -> byte0=00, byte1=02, byte15=10&E1=00. bitwise_done rises 4 edges after accept; in_ready=0 throughout.
- SEW=16, A elements all FFFF, B elements all 0001, vm=1 -> MIN gives all FFFF; MINU gives all 0001; MAX gives all 0001.
- SEW=32 MAX, A={C8,C9,CA,CB}, B={96,97,98,99}, vm=0, vmask=0x0001 -> element0=000000C8, elements 1–3=00000000.
- Reductions:
  - SEW=32 REDXOR, A={1,2,4,8}, B0=0x10, vm=1 -> result[31:0]=0000001F, rest 0.
  - SEW=8 REDMAXU, A byte i = i+1, B0=05 -> byte0=10.
  - SEW=8 REDMAXU with vm=0, vmask=0 -> byte0=05.
- Backpressure: hold out_ready=0 for 3 cycles after done -> result/done stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE and in_ready=1 next cycle; the next command is accepted normally.
- Error and reset:
  - sew=11 -> done after 1 edge, error=1, result=0.
  - Assert reset after 2 RUN beats -> immediately done=0, error=0, result=0, in_ready=1; a subsequent command completes correctly.
